l1_refill_ctrl: RTL and testbench

- L1 miss handler. Accepts one miss at a time, takes the replacement policy's victim way for the miss set, and writes back the victim line if it is dirty.
- Then refills the line from memory, writes the new tag/valid/clean metadata, and reports the filled way to the replacement policy.
- Sits between the L1 lookup pipeline, the tag/data arrays, the way-replacement block and the memory port.
- Drives the access side of the replacement block, which is the consumer of its victim output.

---
 rtl/l1_refill_ctrl_pkg.sv | 32 +++
 rtl/l1_refill_ctrl_if.sv | 25 ++
 rtl/l1_wb_skid.sv | 35 +++
 rtl/l1_refill_ctrl.sv | 151 +++++++++++++++
 tb/tb_l1_refill_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_refill_ctrl_pkg.sv
// Shared widths, refill FSM state encoding and line address helper for the L1 refill controller.
package l1_cache_pkg;

  localparam int unsigned NUM_SETS   = 64;
  localparam int unsigned NUM_WAYS   = 4;
  localparam int unsigned LINE_BEATS = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;

  localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
  localparam int unsigned WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned BEAT_BITS  = $clog2(LINE_BEATS);
  localparam int unsigned OFF_BITS   = BEAT_BITS + $clog2(DATA_W / 8);
  localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - OFF_BITS;

  typedef enum logic [2:0] {
    StIdle,
    StMetaRd,
    StMetaChk,
    StWbReq,
    StWbData,
    StRfReq,
    StRfData,
    StCommit
  } refill_state_e;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_BITS-1:0]   tag,
                                                  input logic [INDEX_BITS-1:0] index);
    return {tag, index, {OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l1_refill_ctrl_if.sv
// Memory port of the refill controller: request channel, writeback data channel, refill data.
interface l1_refill_ctrl_if;
  import l1_cache_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_valid, req_we, req_addr, wvalid, wdata,
    input  req_ready, wready, rvalid, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, wvalid, wdata,
    output req_ready, wready, rvalid, rdata
  );

endinterface

// File: rtl/l1_wb_skid.sv
// One-entry skid register between the data array read port and the writeback data channel.
module l1_wb_skid
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              full
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  // Read data is only valid for one cycle, so park it when the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && !full_q && !out_ready) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (full_q && out_ready) begin
      full_q <= 1'b0;
    end
  end

  assign out_valid = full_q | in_valid;
  assign out_data  = full_q ? data_q : in_data;
  assign full      = full_q;

endmodule

// File: rtl/l1_refill_ctrl.sv
// L1 miss handler: picks the victim, writes it back if dirty, refills the line and commits metadata.
module l1_refill_ctrl
  import l1_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  miss_done,
  output logic [WAY_BITS-1:0]   miss_way,
  output logic [INDEX_BITS-1:0] victim_index,
  input  logic [WAY_BITS-1:0]   victim_way,
  output logic                  repl_access_en,
  output logic [INDEX_BITS-1:0] repl_access_index,
  output logic [WAY_BITS-1:0]   repl_access_way,
  output logic                  meta_rd_en,
  output logic [INDEX_BITS-1:0] meta_idx,
  output logic [WAY_BITS-1:0]   meta_way,
  input  logic                  meta_rd_valid,
  input  logic                  meta_rd_dirty,
  input  logic [TAG_BITS-1:0]   meta_rd_tag,
  output logic                  meta_wr_en,
  output logic [TAG_BITS-1:0]   meta_wr_tag,
  output logic                  data_rd_en,
  output logic                  data_wr_en,
  output logic [INDEX_BITS-1:0] data_idx,
  output logic [WAY_BITS-1:0]   data_way,
  output logic [BEAT_BITS-1:0]  data_beat,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic [DATA_W-1:0]     data_rdata,
  l1_refill_ctrl_if.master      mem
);

  refill_state_e         state_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [WAY_BITS-1:0]   way_q;
  logic [BEAT_BITS-1:0]  beat_q;
  logic [ADDR_W-1:0]     wb_addr_q;
  logic                  rd_pending_q;
  logic                  skid_full;
  logic                  last_beat;
  logic                  wb_fire;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic                  unused_offset;

  assign miss_tag      = miss_addr[ADDR_W-1 -: TAG_BITS];
  assign miss_index    = miss_addr[OFF_BITS +: INDEX_BITS];
  assign unused_offset = ^miss_addr[OFF_BITS-1:0];
  assign last_beat     = (beat_q == BEAT_BITS'(LINE_BEATS - 1));
  assign wb_fire       = mem.wvalid & mem.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      index_q      <= '0;
      way_q        <= '0;
      beat_q       <= '0;
      wb_addr_q    <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= data_rd_en;
      unique case (state_q)
        StIdle: begin
          if (miss_valid) begin
            tag_q   <= miss_tag;
            index_q <= miss_index;
            way_q   <= victim_way;
            state_q <= StMetaRd;
          end
        end
        StMetaRd:  state_q <= StMetaChk;
        StMetaChk: begin
          if (meta_rd_valid && meta_rd_dirty) begin
            wb_addr_q <= line_addr(meta_rd_tag, index_q);
            state_q   <= StWbReq;
          end else begin
            state_q   <= StRfReq;
          end
        end
        StWbReq: begin
          if (mem.req_ready) begin
            beat_q  <= '0;
            state_q <= StWbData;
          end
        end
        StWbData: begin
          if (wb_fire) begin
            beat_q <= beat_q + BEAT_BITS'(1);
            if (last_beat) state_q <= StRfReq;
          end
        end
        StRfReq: begin
          if (mem.req_ready) begin
            beat_q  <= '0;
            state_q <= StRfData;
          end
        end
        StRfData: begin
          if (mem.rvalid) begin
            beat_q <= beat_q + BEAT_BITS'(1);
            if (last_beat) state_q <= StCommit;
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    miss_ready        = (state_q == StIdle);
    // The replacement block answers combinationally, so present the incoming set while idle.
    victim_index      = (state_q == StIdle) ? miss_index : index_q;
    meta_rd_en        = (state_q == StMetaRd);
    meta_idx          = index_q;
    meta_way          = way_q;
    meta_wr_en        = (state_q == StCommit);
    meta_wr_tag       = tag_q;
    // Only one writeback beat in flight: read again once the previous beat has left.
    data_rd_en        = (state_q == StWbData) && !rd_pending_q && !skid_full;
    data_wr_en        = (state_q == StRfData) && mem.rvalid;
    data_idx          = index_q;
    data_way          = way_q;
    data_beat         = beat_q;
    data_wdata        = mem.rdata;
    mem.req_valid     = (state_q == StWbReq) || (state_q == StRfReq);
    mem.req_we        = (state_q == StWbReq);
    mem.req_addr      = (state_q == StWbReq) ? wb_addr_q : line_addr(tag_q, index_q);
    miss_done         = (state_q == StCommit);
    miss_way          = way_q;
    repl_access_en    = (state_q == StCommit);
    repl_access_index = index_q;
    repl_access_way   = way_q;
  end

  l1_wb_skid u_wb_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pending_q),
    .in_data   (data_rdata),
    .out_valid (mem.wvalid),
    .out_data  (mem.wdata),
    .out_ready (mem.wready),
    .full      (skid_full)
  );

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Scoreboard bench for l1_refill_ctrl: directed misses, memory/array responders and an output monitor.
module tb_l1_refill_ctrl;
  import l1_cache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_valid;
  logic                  miss_ready;
  logic [ADDR_W-1:0]     miss_addr;
  logic                  miss_done;
  logic [WAY_BITS-1:0]   miss_way;
  logic [INDEX_BITS-1:0] victim_index;
  logic [WAY_BITS-1:0]   victim_way;
  logic                  repl_access_en;
  logic [INDEX_BITS-1:0] repl_access_index;
  logic [WAY_BITS-1:0]   repl_access_way;
  logic                  meta_rd_en;
  logic [INDEX_BITS-1:0] meta_idx;
  logic [WAY_BITS-1:0]   meta_way;
  logic                  meta_rd_valid;
  logic                  meta_rd_dirty;
  logic [TAG_BITS-1:0]   meta_rd_tag;
  logic                  meta_wr_en;
  logic [TAG_BITS-1:0]   meta_wr_tag;
  logic                  data_rd_en;
  logic                  data_wr_en;
  logic [INDEX_BITS-1:0] data_idx;
  logic [WAY_BITS-1:0]   data_way;
  logic [BEAT_BITS-1:0]  data_beat;
  logic [DATA_W-1:0]     data_wdata;
  logic [DATA_W-1:0]     data_rdata;

  l1_refill_ctrl_if mem_if ();

  always #5 clk = ~clk;

  l1_refill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .miss_valid        (miss_valid),
    .miss_ready        (miss_ready),
    .miss_addr         (miss_addr),
    .miss_done         (miss_done),
    .miss_way          (miss_way),
    .victim_index      (victim_index),
    .victim_way        (victim_way),
    .repl_access_en    (repl_access_en),
    .repl_access_index (repl_access_index),
    .repl_access_way   (repl_access_way),
    .meta_rd_en        (meta_rd_en),
    .meta_idx          (meta_idx),
    .meta_way          (meta_way),
    .meta_rd_valid     (meta_rd_valid),
    .meta_rd_dirty     (meta_rd_dirty),
    .meta_rd_tag       (meta_rd_tag),
    .meta_wr_en        (meta_wr_en),
    .meta_wr_tag       (meta_wr_tag),
    .data_rd_en        (data_rd_en),
    .data_wr_en        (data_wr_en),
    .data_idx          (data_idx),
    .data_way          (data_way),
    .data_beat         (data_beat),
    .data_wdata        (data_wdata),
    .data_rdata        (data_rdata),
    .mem               (mem_if.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, repl_cnt = 0, wb_cnt = 0;
  bit chk_lat = 0;

  logic [63:0] q_req[$], q_wb[$], q_dwr[$], q_meta[$], q_repl[$], q_done[$];

  // Responder configuration
  logic                cfg_meta_valid = 0, cfg_meta_dirty = 0, cfg_bp = 0, stray_rvalid = 0;
  logic [TAG_BITS-1:0] cfg_meta_tag = '0;
  logic [DATA_W-1:0]   cfg_wb_base = '0, cfg_rf_base = '0;
  int                  cfg_req_delay = 0;
  int                  wpat_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int ch, input string name, input logic [63:0] act);
    logic [63:0] e;
    int          n;
    case (ch)
      0:       n = q_req.size();
      1:       n = q_wb.size();
      2:       n = q_dwr.size();
      3:       n = q_meta.size();
      4:       n = q_repl.size();
      default: n = q_done.size();
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected output %h, expected none (t=%0t)", name, act, $time);
    end else begin
      case (ch)
        0:       e = q_req.pop_front();
        1:       e = q_wb.pop_front();
        2:       e = q_dwr.pop_front();
        3:       e = q_meta.pop_front();
        4:       e = q_repl.pop_front();
        default: e = q_done.pop_front();
      endcase
      chk(name, act, e);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  initial begin
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (data_rd_en || data_wr_en) chk("rd_wr_exclusive", 64'(data_rd_en & data_wr_en), 0);
        if (miss_valid && miss_ready) begin
          acc_cnt++;
          acc_cyc = cyc;
        end
        if (mem_if.req_valid && mem_if.req_ready)
          pop_chk(0, "mem_req", {31'd0, mem_if.req_we, mem_if.req_addr});
        if (prev_stall) chk("wdata_stable", {31'd0, mem_if.wvalid, mem_if.wdata}, {31'd0, 1'b1, prev_wdata});
        prev_stall = mem_if.wvalid && !mem_if.wready;
        prev_wdata = mem_if.wdata;
        if (mem_if.wvalid && mem_if.wready) begin
          pop_chk(1, "mem_wdata", 64'(mem_if.wdata));
          wb_cnt++;
        end
        if (data_wr_en) pop_chk(2, "data_wr", {22'd0, data_idx, data_way, data_beat, data_wdata});
        if (meta_wr_en) pop_chk(3, "meta_wr_tag", 64'(meta_wr_tag));
        if (repl_access_en) begin
          pop_chk(4, "repl_access", 64'({repl_access_index, repl_access_way}));
          repl_cnt++;
        end
        if (miss_done) begin
          pop_chk(5, "miss_way", 64'(miss_way));
          if (chk_lat) chk("done_latency", 64'(cyc - acc_cyc), 64'(4 + LINE_BEATS));
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // Responders: metadata/data arrays (1-cycle latency) and the memory port.
  initial begin
    logic                 s_meta, s_rd;
    logic [BEAT_BITS-1:0] s_beat;
    int                   req_wait = 0, rf_left = 0, rf_cnt = 0;
    meta_rd_valid = 0; meta_rd_dirty = 0; meta_rd_tag = '0; data_rdata = 32'hDEAD_BEEF;
    mem_if.req_ready = 0; mem_if.wready = 0; mem_if.rvalid = 0; mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      s_meta = meta_rd_en;
      s_rd   = data_rd_en;
      s_beat = data_beat;
      if (rst) begin
        rf_left  = 0;
        req_wait = 0;
      end else begin
        if (mem_if.req_valid && mem_if.req_ready) begin
          req_wait = 0;
          if (!mem_if.req_we) begin
            rf_left = LINE_BEATS;
            rf_cnt  = 0;
          end
        end else if (mem_if.req_valid) begin
          req_wait++;
        end
        if (mem_if.wvalid) wpat_idx++;
      end
      @(posedge clk);
      #1;
      meta_rd_valid    = s_meta ? cfg_meta_valid : 1'b0;
      meta_rd_dirty    = s_meta ? cfg_meta_dirty : 1'b0;
      meta_rd_tag      = s_meta ? cfg_meta_tag : '0;
      data_rdata       = s_rd ? cfg_wb_base + DATA_W'(s_beat) : 32'hDEAD_BEEF;
      mem_if.req_ready = (req_wait >= cfg_req_delay);
      mem_if.wready    = cfg_bp ? (wpat_idx % 3 == 0) : 1'b1;
      if (rf_left > 0) begin
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = cfg_rf_base + DATA_W'(rf_cnt);
        rf_cnt++;
        rf_left--;
      end else begin
        mem_if.rvalid = stray_rvalid;
        mem_if.rdata  = stray_rvalid ? 32'hEEEE_EEEE : '0;
      end
    end
  end

  task automatic wait_acc(input int target, input string name);
    int n = 0;
    while (acc_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(acc_cnt >= target), 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 64'(done_cnt >= target), 1);
  endtask

  task automatic configure(input logic [WAY_BITS-1:0] vway, input logic mvalid, input logic mdirty,
                           input logic [TAG_BITS-1:0] mtag, input logic [DATA_W-1:0] wb_base,
                           input logic [DATA_W-1:0] rf_base, input int delay, input logic bp);
    victim_way = vway; cfg_meta_valid = mvalid; cfg_meta_dirty = mdirty; cfg_meta_tag = mtag;
    cfg_wb_base = wb_base; cfg_rf_base = rf_base; cfg_req_delay = delay; cfg_bp = bp; wpat_idx = 0;
  endtask

  // Expectations for one complete miss; wb_addr=0 means the victim is clean.
  task automatic push_miss(input logic [INDEX_BITS-1:0] idx, input logic [TAG_BITS-1:0] tag,
                           input logic [WAY_BITS-1:0] way, input logic [ADDR_W-1:0] rf_addr,
                           input logic [ADDR_W-1:0] wb_addr, input logic [DATA_W-1:0] wb_base,
                           input logic [DATA_W-1:0] rf_base);
    logic [BEAT_BITS-1:0] b;
    if (wb_addr != 0) begin
      q_req.push_back({31'd0, 1'b1, wb_addr});
      for (int i = 0; i < LINE_BEATS; i++) q_wb.push_back(64'(wb_base + DATA_W'(i)));
    end
    q_req.push_back({31'd0, 1'b0, rf_addr});
    for (int i = 0; i < LINE_BEATS; i++) begin
      b = BEAT_BITS'(i);
      q_dwr.push_back({22'd0, idx, way, b, rf_base + DATA_W'(i)});
    end
    q_meta.push_back(64'(tag));
    q_repl.push_back(64'({idx, way}));
    q_done.push_back(64'(way));
  endtask

  task automatic run_miss(input logic [ADDR_W-1:0] addr, input string name);
    int a0 = acc_cnt, d0 = done_cnt;
    miss_valid = 1'b1;
    miss_addr  = addr;
    wait_acc(a0 + 1, {name, "_accept"});
    miss_valid = 1'b0;
    wait_done(d0 + 1, {name, "_done"});
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    chk(name, 64'({miss_ready, meta_rd_en, meta_wr_en, data_rd_en, data_wr_en, mem_if.req_valid,
                   mem_if.wvalid, miss_done, repl_access_en}), 64'(9'b1_0000_0000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Address split: offset [3:0], index [9:4], tag [31:10].
  initial begin
    int r0, a0;
    rst = 1'b1; miss_valid = 1'b0; miss_addr = '0; victim_way = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset_state");
    chk("reset_victim_index", 64'(victim_index), 0);

    // Clean miss, zero-wait memory: 0x1230 -> idx 0x23, tag 0x4
    @(posedge clk); #1;
    configure(2'd2, 0, 0, '0, 32'hB0, 32'hA0, 0, 0);
    push_miss(6'h23, 22'h4, 2'd2, 32'h0000_1230, 32'h0, 32'hB0, 32'hA0);
    chk_lat = 1;
    run_miss(32'h0000_1230, "clean");
    chk_lat = 0;

    // Dirty victim tag 0x55 at idx 0x23 -> writeback to 0x15630
    configure(2'd2, 1, 1, 22'h55, 32'hB0, 32'hA0, 0, 0);
    push_miss(6'h23, 22'h4, 2'd2, 32'h0000_1230, 32'h0001_5630, 32'hB0, 32'hA0);
    run_miss(32'h0000_1234, "dirty");

    // Backpressure: 0x8A40 -> idx 0x24, tag 0x22; victim tag 0x3C -> writeback 0xF240
    configure(2'd1, 1, 1, 22'h3C, 32'hC0, 32'hD0, 3, 1);
    push_miss(6'h24, 22'h22, 2'd1, 32'h0000_8A40, 32'h0000_F240, 32'hC0, 32'hD0);
    run_miss(32'h0000_8A40, "backpressure");

    // Reset after writeback beat 1
    configure(2'd3, 1, 1, 22'h55, 32'hB0, 32'hA0, 0, 0);
    q_req.push_back({31'd0, 1'b1, 32'h0001_5630});
    q_wb.push_back(64'(32'hB0));
    q_wb.push_back(64'(32'hB1));
    a0 = wb_cnt + 2;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1230;
    for (int n = 0; n < 100 && wb_cnt < a0; n++) begin
      @(posedge clk); #1;
      if (acc_cnt > 0) miss_valid = 1'b0;
    end
    chk("wb_two_beats_before_reset", 64'(wb_cnt), 64'(a0));
    miss_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_midwb_reset");
    @(posedge clk); #1;
    configure(2'd0, 0, 0, '0, 32'hB0, 32'hA0, 0, 0);
    push_miss(6'h23, 22'h4, 2'd0, 32'h0000_1230, 32'h0, 32'hB0, 32'hA0);
    chk_lat = 1;
    run_miss(32'h0000_1230, "post_reset");
    chk_lat = 0;

    // Back-to-back with miss_valid held: 0x4A5C -> idx 0x25 tag 0x12; 0xFFF0 -> idx 0x3F tag 0x3F
    configure(2'd1, 0, 0, '0, 32'h0, 32'h70, 0, 0);
    push_miss(6'h25, 22'h12, 2'd1, 32'h0000_4A50, 32'h0, 32'h0, 32'h70);
    push_miss(6'h3F, 22'h3F, 2'd1, 32'h0000_FFF0, 32'h0, 32'h0, 32'h70);
    r0 = repl_cnt;
    a0 = acc_cnt;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_4A5C;
    wait_acc(a0 + 1, "b2b_first_accept");
    miss_addr  = 32'h0000_FFF0;
    wait_acc(a0 + 2, "b2b_second_accept");
    chk("b2b_accept_after_done", 64'(acc_cyc - done_cyc), 1);
    miss_valid = 1'b0;
    wait_done(done_cnt + 1, "b2b_second_done");
    repeat (3) @(posedge clk);
    chk("b2b_repl_pulses", 64'(repl_cnt - r0), 2);

    // Stray refill beats while idle
    #1 stray_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_miss_ready", 64'(miss_ready), 1);
      chk("stray_no_data_wr", 64'(data_wr_en), 0);
    end
    @(posedge clk); #1 stray_rvalid = 1'b0;
    @(negedge clk);
    check_idle("stray_idle");

    chk("q_req_empty", 64'(q_req.size()), 0);
    chk("q_wb_empty", 64'(q_wb.size()), 0);
    chk("q_dwr_empty", 64'(q_dwr.size()), 0);
    chk("q_done_empty", 64'(q_done.size() + q_meta.size() + q_repl.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
